conv_encoder_punct: RTL and testbench

- Parametrised successor of the fixed K=7 rate-1/2 convolutional encoder in the 802.11a transmitter chain.
- Generalised in three ways:
  - configurable constraint length and generator polynomials;
  - run-time puncturing to rates 1/2, 2/3 and 3/4 per 802.11a clause 17.3.5.6;
  - a valid/ready handshake on both sides, emitting one coded bit per cycle.
- Sits between the scrambler and the interleaver.

---
 rtl/conv_encoder_punct_pkg.sv | 47 ++++
 rtl/conv_puncture.sv | 75 +++++++
 rtl/conv_encoder_punct.sv | 67 ++++++
 tb/tb_conv_encoder_punct.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_punct_pkg.sv
// Shared definitions for the punctured convolutional encoder:
// rate encodings, 802.11a default generators and the puncture keep mask.
package conv_encoder_punct_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'b00,
        RATE_2_3 = 2'b01,
        RATE_3_4 = 2'b10
    } rate_e;

    localparam logic [6:0] G0_80211A = 7'o133;
    localparam logic [6:0] G1_80211A = 7'o171;

    // The reserved encoding 2'b11 behaves as rate 1/2.
    function automatic rate_e decode_rate(input logic [1:0] r);
        case (r)
            2'b01:   return RATE_2_3;
            2'b10:   return RATE_3_4;
            default: return RATE_1_2;
        endcase
    endfunction

    // Number of phases in the puncture pattern for a given rate.
    function automatic logic [1:0] punct_len(input rate_e r);
        case (r)
            RATE_2_3: return 2'd2;
            RATE_3_4: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

    // Returns {keep_b, keep_a} for the given rate and phase.
    function automatic logic [1:0] keep_mask(input rate_e r, input logic [1:0] phase);
        case (r)
            RATE_2_3: return (phase == 2'd0) ? 2'b11 : 2'b01;
            RATE_3_4: begin
                case (phase)
                    2'd0:    return 2'b11;
                    2'd1:    return 2'b01;
                    default: return 2'b10;
                endcase
            end
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/conv_puncture.sv
// Puncturing and serialisation: tracks the puncture phase, selects which
// of the A/B coded bits survive, and emits them A-before-B from a
// 2-entry hold register under a valid/ready handshake.
module conv_puncture
    import conv_encoder_punct_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rate,
    input  logic       accept,
    input  logic       a,
    input  logic       b,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit
);

    rate_e      rate_q;
    logic [1:0] phase;
    logic [1:0] hold;
    logic [1:0] cnt;
    logic [1:0] keep;
    logic       pop;

    assign keep      = keep_mask(rate_q, phase);
    assign out_valid = (cnt != 2'd0);
    assign out_bit   = hold[0];
    assign pop       = out_valid && out_ready;
    // A new input may load only when the hold register empties this cycle.
    assign in_ready  = !start && ((cnt == 2'd0) || ((cnt == 2'd1) && out_ready));

    // Phase counter, rate latch and hold/serialiser state.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rate_q <= RATE_1_2;
            phase  <= 2'd0;
            // NOTE: the hold register drives out_bit directly, so it is reset
            // along with the control state to give a defined idle output.
            hold   <= 2'b00;
            cnt    <= 2'd0;
        end else if (start) begin
            rate_q <= decode_rate(rate);
            phase  <= 2'd0;
            hold   <= 2'b00;
            cnt    <= 2'd0;
        end else if (accept) begin
            phase <= (phase == punct_len(rate_q) - 2'd1) ? 2'd0 : phase + 2'd1;
            case (keep)
                2'b11: begin
                    hold <= {b, a};
                    cnt  <= 2'd2;
                end
                2'b01: begin
                    hold <= {1'b0, a};
                    cnt  <= 2'd1;
                end
                2'b10: begin
                    hold <= {1'b0, b};
                    cnt  <= 2'd1;
                end
                default: begin
                    hold <= 2'b00;
                    cnt  <= 2'd0;
                end
            endcase
        end else if (pop) begin
            hold <= {1'b0, hold[1]};
            cnt  <= cnt - 2'd1;
        end
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// Parametrised rate-1/2 convolutional encoder with run-time puncturing to
// 2/3 and 3/4. Owns the K-1 stage shift register and generator tap XORs;
// puncturing and output serialisation live in conv_puncture.
module conv_encoder_punct
    import conv_encoder_punct_pkg::*;
#(
    parameter int         K  = 7,
    parameter logic [K-1:0] G0 = G0_80211A,
    parameter logic [K-1:0] G1 = G1_80211A
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] rate,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready
);

    // sr[i] is register stage i; stage 1 holds the most recent input.
    logic [K-1:1] sr;
    logic         a;
    logic         b;
    logic         accept;

    assign accept = in_valid && in_ready;

    // Generator taps: bit K-1 taps the current input, bit K-1-i taps stage i.
    // NOTE: defaults are assigned first so no path can infer a latch.
    always_comb begin
        a = G0[K-1] & in_bit;
        b = G1[K-1] & in_bit;
        for (int i = 1; i < K; i++) begin
            a = a ^ (G0[K-1-i] & sr[i]);
            b = b ^ (G1[K-1-i] & sr[i]);
        end
    end

    // Shift register: cleared on frame start, shifts on every accepted bit.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (start) begin
            sr <= '0;
        end else if (accept) begin
            sr <= {sr[K-2:1], in_bit};
        end
    end

    conv_puncture u_puncture (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
        .rate      (rate),
        .accept    (accept),
        .a         (a),
        .b         (b),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit)
    );

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: table of hand-computed frames plus
// hand-written sequences for back-pressure, mid-frame start and reset.
module tb_conv_encoder_punct;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rate = 2'b00;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;

    int tests = 0;
    int fails = 0;

    logic got_q[$];
    logic exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  rate;
        int          n_in;
        logic [15:0] in_bits;   // bit 0 is sent first
        int          n_out;
        logic [15:0] out_bits;  // bit 0 is expected first
    } vec_t;

    vec_t vecs[5];

    always #5 Clk = ~Clk;

    conv_encoder_punct dut (
        .Clk       (Clk),
        .reset     (reset),
        .rate      (rate),
        .start     (start),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: one-cycle start pulse latching rate r.
    task automatic do_start(input logic [1:0] r);
        start     = 1'b1;
        rate      = r;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    // Feed n bits, collect emitted bits into got_q. stall[c]=1 drops
    // out_ready in cycle c; during a stall the head bit must hold.
    task automatic run_stream(input string name, input int n, input logic [15:0] bits,
                              input logic [31:0] stall);
        int   idx = 0;
        int   cyc = 0;
        logic held = 1'b0;
        logic was_stalled = 1'b0;
        got_q.delete();
        while ((idx < n || out_valid) && cyc < 300) begin
            in_valid  = (idx < n);
            in_bit    = (idx < n) ? bits[idx] : 1'b0;
            out_ready = (cyc < 32) ? !stall[cyc] : 1'b1;
            @(negedge Clk);
            if (out_valid && !out_ready) begin
                check({name, " stall in_ready"}, {31'b0, in_ready}, 32'd0);
                if (was_stalled)
                    check({name, " held out_bit"}, {31'b0, out_bit}, {31'b0, held});
                held        = out_bit;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) got_q.push_back(out_bit);
            if (in_valid && in_ready) idx++;
            @(posedge Clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d inputs accepted, required %0d", name, idx, n);
        end
    endtask

    // Golden model: 802.11a 133/171 taps written out explicitly plus the
    // puncture patterns, starting from a cleared register.
    task automatic model(input logic [1:0] r, input int n, input logic [15:0] bits);
        logic [6:1] d = '0;
        int         ph = 0;
        int         len;
        logic       x, ma, mb, keep_a, keep_b;
        len = (r == 2'b01) ? 2 : (r == 2'b10) ? 3 : 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            x  = bits[i];
            ma = x ^ d[2] ^ d[3] ^ d[5] ^ d[6];
            mb = x ^ d[1] ^ d[2] ^ d[3] ^ d[6];
            keep_a = !(r == 2'b10 && ph == 2);
            keep_b = !(ph == 1 && (r == 2'b01 || r == 2'b10));
            if (keep_a) exp_q.push_back(ma);
            if (keep_b) exp_q.push_back(mb);
            d  = {d[5:1], x};
            ph = (ph + 1) % len;
        end
    endtask

    task automatic compare(input string name);
        check({name, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s bit%0d", name, i), {31'b0, got_q[i]}, {31'b0, exp_q[i]});
    endtask

    initial begin
        logic [3:0]  tog;
        logic [15:0] rbits;

        vecs[0] = '{"r12_10",   2'b00, 2, 16'h0001, 4, 16'h000B};
        vecs[1] = '{"r34_1000", 2'b10, 4, 16'h0001, 6, 16'h003B};
        vecs[2] = '{"r12_1101", 2'b00, 4, 16'h000B, 8, 16'h00D7};
        vecs[3] = '{"rsvd_1",   2'b11, 1, 16'h0001, 2, 16'h0003};
        vecs[4] = '{"r23_1011", 2'b01, 4, 16'h000D, 6, 16'h0003};

        // Reset state while reset is held low.
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_bit",   {31'b0, out_bit},   32'd0);
        check("reset in_ready",  {31'b0, in_ready},  32'd1);
        reset = 1'b1;
        @(posedge Clk); #1;

        // Rate 1/2 with continuous input: in_ready toggles 1,0,1,0.
        do_start(2'b00);
        tog       = 4'b0101;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check($sformatf("toggle in_ready c%0d", k), {31'b0, in_ready}, {31'b0, tog[k]});
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;

        // Table-driven frames with hand-computed outputs.
        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].rate);
            run_stream(vecs[v].name, vecs[v].n_in, vecs[v].in_bits, 32'd0);
            exp_q.delete();
            for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(vecs[v].out_bits[i]);
            compare(vecs[v].name);
        end

        // Rate 2/3, random bits against the golden model.
        rbits = 16'($urandom);
        do_start(2'b01);
        run_stream("r23_rand", 4, rbits, 32'd0);
        model(2'b01, 4, rbits);
        compare("r23_rand");

        // Back-pressure: out_ready low for cycles 3..7 at rate 3/4.
        rbits = 16'($urandom);
        do_start(2'b10);
        run_stream("bp_r34", 8, rbits, 32'h0000_00F8);
        model(2'b10, 8, rbits);
        compare("bp_r34");

        // start with one bit pending and a valid input on the same cycle.
        do_start(2'b00);
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b0;
        @(posedge Clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check("mid pending valid", {31'b0, out_valid}, 32'd1);
        check("mid pending bit",   {31'b0, out_bit},   32'd1);
        start     = 1'b1;
        rate      = 2'b10;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        @(negedge Clk);
        check("mid start in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge Clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        rate     = 2'b00;
        check("mid start out_valid", {31'b0, out_valid}, 32'd0);
        run_stream("after_start_r34", 3, 16'h0001, 32'd0);
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        compare("after_start_r34");

        // Asynchronous reset mid-frame, then default rate 1/2 from clear.
        do_start(2'b01);
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b0;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset out_valid", {31'b0, out_valid}, 32'd0);
        check("async reset in_ready",  {31'b0, in_ready},  32'd1);
        reset = 1'b1;
        @(posedge Clk); #1;
        run_stream("after_reset", 2, 16'h0001, 32'd0);
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        compare("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
